// File: rtl/addsub_div_ctrl_if.sv
// Request/result bundle between a division requester and addsub_div_ctrl.
// The requester drives start and the operands. The controller returns the results and status.
interface addsub_div_ctrl_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             busy;
  logic             done;
  logic             div_zero;

  modport master (
    output start, dividend, divisor,
    input  quotient, remainder, busy, done, div_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output quotient, remainder, busy, done, div_zero
  );
endinterface

// File: rtl/addsub_div_ctrl.sv
// 4-bit unsigned restoring divider sequenced over a shared add/sub datapath.
// Each cycle performs one trial subtraction. Divide-by-zero bypasses the iteration loop.

// 4-bit adder/subtractor: k=1 subtracts b from a, and cout=1 then means no borrow (a >= b).
module adder_subtractor (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       k,
  output logic [3:0] sum,
  output logic       cout
);
  logic [4:0] full;

  // Two's-complement subtract: invert b and inject k as the carry-in.
  assign full = {1'b0, a} + {1'b0, b ^ {4{k}}} + {4'b0000, k};
  assign sum  = full[3:0];
  assign cout = full[4];
endmodule

// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; results and div_zero hold their values
// CALC  | one restoring-division iteration per edge, 4 in total
// DONE  | single-cycle done pulse; start is ignored
module addsub_div_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  addsub_div_ctrl_if.slave   bus
);
  if (WIDTH != 4) begin : g_width_check
    $error("addsub_div_ctrl: WIDTH must be 4 to match the 4-bit add/sub datapath");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] LAST_ITER = 2'(WIDTH - 1);

  state_t           state, state_n;
  logic [WIDTH-1:0] q_reg, q_n;
  logic [WIDTH-1:0] d_reg, d_n;
  // The partial remainder entering an iteration is always below 2^(WIDTH-1), so its
  // top bit is not stored. Only the final remainder can reach the full width.
  logic [WIDTH-2:0] r_reg, r_n;
  logic [1:0]       cnt, cnt_n;
  logic [WIDTH-1:0] quo, quo_n;
  logic [WIDTH-1:0] rem, rem_n;
  logic             dz, dz_n;

  logic [WIDTH-1:0] trial;
  logic [WIDTH-1:0] diff;
  logic             no_borrow;
  logic [WIDTH-1:0] r_new;
  logic [WIDTH-1:0] q_new;

  // Shift the next dividend bit into the partial remainder. This forms the trial value.
  assign trial = {r_reg, q_reg[WIDTH-1]};

  adder_subtractor u_addsub (
    .a    (trial),
    .b    (d_reg),
    .k    (1'b1),
    .sum  (diff),
    .cout (no_borrow)
  );

  // Restore on borrow. The quotient bit is the no-borrow flag.
  assign r_new = no_borrow ? diff : trial;
  assign q_new = {q_reg[WIDTH-2:0], no_borrow};

  assign bus.quotient  = quo;
  assign bus.remainder = rem;
  assign bus.div_zero  = dz;
  assign bus.busy      = (state != IDLE);
  assign bus.done      = (state == DONE);

  // State and datapath registers, cleared asynchronously so an abort leaves no trace.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      q_reg <= '0;
      d_reg <= '0;
      r_reg <= '0;
      cnt   <= '0;
      quo   <= '0;
      rem   <= '0;
      dz    <= 1'b0;
    end else begin
      state <= state_n;
      q_reg <= q_n;
      d_reg <= d_n;
      r_reg <= r_n;
      cnt   <= cnt_n;
      quo   <= quo_n;
      rem   <= rem_n;
      dz    <= dz_n;
    end
  end

  // Next-state and next-datapath logic; everything holds unless a state acts on it.
  always_comb begin
    state_n = state;
    q_n     = q_reg;
    d_n     = d_reg;
    r_n     = r_reg;
    cnt_n   = cnt;
    quo_n   = quo;
    rem_n   = rem;
    dz_n    = dz;

    case (state)
      IDLE: begin
        if (bus.start) begin
          if (bus.divisor != '0) begin
            q_n     = bus.dividend;
            d_n     = bus.divisor;
            r_n     = '0;
            cnt_n   = '0;
            dz_n    = 1'b0;
            state_n = CALC;
          end else begin
            quo_n   = '1;
            rem_n   = bus.dividend;
            dz_n    = 1'b1;
            state_n = DONE;
          end
        end
      end
      CALC: begin
        r_n   = r_new[WIDTH-2:0];
        q_n   = q_new;
        cnt_n = cnt + 2'd1;
        if (cnt == LAST_ITER) begin
          quo_n   = q_new;
          rem_n   = r_new;
          state_n = DONE;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end
endmodule

// File: tb/tb_addsub_div_ctrl.sv
// Bench for addsub_div_ctrl: a cycle-level reference model with an every-cycle compare,
// plus directed cases carrying hand-computed results and latencies.
module tb_addsub_div_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  addsub_div_ctrl_if #(.WIDTH(4)) bus ();

  addsub_div_ctrl #(.WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model. m_left counts the remaining busy cycles, and the last busy cycle is the done cycle.
  int       m_left = 0;
  logic [3:0] m_q = 4'd0, m_r = 4'd0, p_q = 4'd0, p_r = 4'd0;
  logic       m_dz = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_left <= 0;
      m_q    <= 4'd0;
      m_r    <= 4'd0;
      m_dz   <= 1'b0;
      p_q    <= 4'd0;
      p_r    <= 4'd0;
    end else if (m_left == 0) begin
      if (bus.start) begin
        if (bus.divisor == 4'd0) begin
          m_left <= 1;
          m_q    <= 4'hF;
          m_r    <= bus.dividend;
          m_dz   <= 1'b1;
        end else begin
          m_left <= 5;
          m_dz   <= 1'b0;
          p_q    <= bus.dividend / bus.divisor;
          p_r    <= bus.dividend % bus.divisor;
        end
      end
    end else begin
      m_left <= m_left - 1;
      if (m_left == 2) begin
        m_q <= p_q;
        m_r <= p_r;
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, sampled away from the active edge.
  always @(negedge clk) begin
    chk("model busy", int'(bus.busy), int'(m_left != 0));
    chk("model done", int'(bus.done), int'(m_left == 1));
    chk("model quotient", int'(bus.quotient), int'(m_q));
    chk("model remainder", int'(bus.remainder), int'(m_r));
    chk("model div_zero", int'(bus.div_zero), int'(m_dz));
  end

  // Issue one request and wait for done. Checks latency, busy length and literal results.
  task automatic run_div(input string nm, input logic [3:0] a, input logic [3:0] b,
                         input int eq, input int er, input int edz, input int elat);
    int k;
    int nbusy;
    @(negedge clk);
    bus.dividend = a;
    bus.divisor  = b;
    bus.start    = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    k = 1;
    nbusy = int'(bus.busy);
    while (!bus.done && k < 12) begin
      @(negedge clk);
      k++;
      nbusy += int'(bus.busy);
    end
    chk({nm, " latency"}, k, elat);
    chk({nm, " busy cycles"}, nbusy, elat);
    chk({nm, " quotient"}, int'(bus.quotient), eq);
    chk({nm, " remainder"}, int'(bus.remainder), er);
    chk({nm, " div_zero"}, int'(bus.div_zero), edz);
  endtask

  initial begin
    int k;
    int ndone;
    bus.start    = 1'b0;
    bus.dividend = 4'd0;
    bus.divisor  = 4'd0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;

    @(negedge clk);
    chk("reset quotient", int'(bus.quotient), 0);
    chk("reset remainder", int'(bus.remainder), 0);
    chk("reset busy", int'(bus.busy), 0);
    chk("reset done", int'(bus.done), 0);
    chk("reset div_zero", int'(bus.div_zero), 0);

    run_div("13/3", 4'd13, 4'd3, 4, 1, 0, 5);
    run_div("15/1", 4'd15, 4'd1, 15, 0, 0, 5);
    run_div("7/9", 4'd7, 4'd9, 0, 7, 0, 5);
    run_div("15/15", 4'd15, 4'd15, 1, 0, 0, 5);
    run_div("15/9", 4'd15, 4'd9, 1, 6, 0, 5);
    run_div("8/9", 4'd8, 4'd9, 0, 8, 0, 5);
    run_div("9/0", 4'd9, 4'd0, 15, 9, 1, 1);
    run_div("10/4", 4'd10, 4'd4, 2, 2, 0, 5);

    // A start pulse and operand changes during the calculation must be ignored.
    @(negedge clk);
    bus.dividend = 4'd13;
    bus.divisor  = 4'd3;
    bus.start    = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    k = 1;
    @(negedge clk);
    k++;
    bus.dividend = 4'd1;
    bus.divisor  = 4'd1;
    bus.start    = 1'b1;
    @(negedge clk);
    k++;
    bus.start    = 1'b0;
    bus.dividend = 4'd7;
    bus.divisor  = 4'd2;
    while (!bus.done && k < 12) begin
      @(negedge clk);
      k++;
    end
    chk("ignore-start latency", k, 5);
    chk("ignore-start quotient", int'(bus.quotient), 4);
    chk("ignore-start remainder", int'(bus.remainder), 1);
    ndone = 0;
    repeat (6) begin
      @(negedge clk);
      ndone += int'(bus.done);
    end
    chk("ignore-start extra done", ndone, 0);

    // An asynchronous reset during the calculation clears everything and produces no done.
    @(negedge clk);
    bus.dividend = 4'd14;
    bus.divisor  = 4'd5;
    bus.start    = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort quotient", int'(bus.quotient), 0);
    chk("abort remainder", int'(bus.remainder), 0);
    chk("abort busy", int'(bus.busy), 0);
    chk("abort done", int'(bus.done), 0);
    @(posedge clk);
    #2 rst = 1'b0;
    ndone = 0;
    repeat (6) begin
      @(negedge clk);
      ndone += int'(bus.done);
    end
    chk("abort no done", ndone, 0);
    run_div("14/5", 4'd14, 4'd5, 2, 4, 0, 5);

    // Exhaustive back-to-back sweep. start stays high, and each new pair is presented in the IDLE cycle.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        @(negedge clk);
        bus.dividend = 4'(a);
        bus.divisor  = 4'(b);
        bus.start    = 1'b1;
        k = 0;
        do begin
          @(negedge clk);
          k++;
        end while (!bus.done && k < 12);
        chk("sweep latency", k, (b == 0) ? 1 : 5);
      end
    end
    bus.start = 1'b0;
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
